// File: rtl/ctr_updown_mod.sv
// ctr_updown_mod: parametrised up/down counter with load, wrap/saturate, Gray output and event pulse
module ctr_updown_mod #(
  parameter int WIDTH = 3,
  parameter int MAX_VALUE = 2**WIDTH-1,
  parameter int STEP = 1,
  parameter int SATURATE = 0
) (
  input  logic             clock,
  input  logic             INIT,
  input  logic             enable,
  input  logic [1:0]       control,
  input  logic [WIDTH-1:0] initial_value,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_gray,
  output logic             terminal,
  output logic             zero,
  output logic             wrapped
);
  localparam logic [WIDTH-1:0] max_n = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] step_n = WIDTH'(STEP);
  localparam logic [WIDTH:0] max_w = (WIDTH+1)'(MAX_VALUE);
  // Modular wrap offsets; the true wrapped result always fits in WIDTH bits
  localparam logic [WIDTH-1:0] up_adj = WIDTH'(STEP - MAX_VALUE - 1);
  localparam logic [WIDTH-1:0] dn_adj = WIDTH'(MAX_VALUE + 1 - STEP);
  logic             go, up_ovf, dn_ovf, nwrap;
  logic [WIDTH-1:0] init_c, up_n, dn_n, nxt;
  always_comb begin
    go = enable && control != 2'b00;
    up_ovf = ({1'b0, count} + {1'b0, step_n}) > max_w;
    dn_ovf = count < step_n;
    init_c = initial_value > max_n ? max_n : initial_value;
    up_n = !up_ovf ? count + step_n : SATURATE != 0 ? max_n : count + up_adj;
    dn_n = !dn_ovf ? count - step_n : SATURATE != 0 ? '0 : count + dn_adj;
    nxt = !go ? count : control == 2'b01 ? init_c : control == 2'b10 ? up_n : dn_n;
    nwrap = go && ((control == 2'b10 && up_ovf) || (control == 2'b11 && dn_ovf));
  end
  always_ff @(posedge clock) begin
    if (INIT) begin
      count <= init_c;
      wrapped <= 1'b0;
    end else begin
      count <= nxt;
      wrapped <= nwrap;
    end
  end
  assign count_gray = count ^ (count >> 1);
  assign terminal = (control == 2'b10 && count == max_n) || (control == 2'b11 && count == '0);
  assign zero = count == '0;
endmodule
